// File: rtl/arc4_pkg.sv
// Shared types and constants for the ARC4 key-scheduling stage.
package arc4_pkg;

  typedef enum logic [2:0] {
    INIT   = 3'd0,
    RD_I   = 3'd1,
    WAIT_I = 3'd2,
    CALC_J = 3'd3,
    WAIT_J = 3'd4,
    WR_I   = 3'd5,
    WR_J   = 3'd6,
    DONE   = 3'd7
  } state_t;

  localparam int S_DEPTH   = 256;
  localparam int KEY_BYTES = 3;

  // Big-endian key byte select: idx 0 is the most significant byte.
  function automatic logic [7:0] key_byte(input logic [23:0] key, input logic [1:0] idx);
    case (idx)
      2'd0:    key_byte = key[23:16];
      2'd1:    key_byte = key[15:8];
      default: key_byte = key[7:0];
    endcase
  endfunction

endpackage

// File: rtl/s_mem.sv
// 256x8 single-port RAM: address registered, q valid the cycle after the address is presented.
module s_mem
  import arc4_pkg::*;
(
  input  logic       clk,
  input  logic [7:0] address,
  input  logic [7:0] data,
  input  logic       wren,
  output logic [7:0] q
);

  logic [7:0] r_mem [0:S_DEPTH-1];
  logic [7:0] r_addr;

  // Register the read address and perform the write on the same edge.
  always_ff @(posedge clk) begin
    r_addr <= address;
    if (wren) r_mem[address] <= data;
  end

  assign q = r_mem[r_addr];

endmodule

// File: rtl/rc4_init_ksa.sv
// ARC4 stage 2: fill S with the identity permutation, then run the KSA in place.
//
// state  | meaning
// -------+-------------------------------------------------
// INIT   | write S[i]=i, one location per cycle
// RD_I   | present address i
// WAIT_I | RAM read latency, S[i] appears on q
// CALC_J | capture si, j += si + key byte, present address j
// WAIT_J | RAM read latency, S[j] appears on q
// WR_I   | write S[i] = sj (taken straight from q)
// WR_J   | write S[j] = si, advance i or finish
// DONE   | hold, done asserted, RAM untouched
module rc4_init_ksa
  import arc4_pkg::*;
(
  input  logic       CLOCK_50,
  input  logic [3:0] KEY,
  input  logic [9:0] SW,
  output logic [9:0] LEDR,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2,
  output logic [6:0] HEX3,
  output logic [6:0] HEX4,
  output logic [6:0] HEX5
);

  state_t      r_state;
  logic [7:0]  r_i;
  logic [7:0]  r_j;
  logic [7:0]  r_si;
  logic [1:0]  r_kidx;
  logic        r_done;

  logic        w_rst_n;
  logic [23:0] w_key;
  logic [7:0]  w_kbyte;
  logic [7:0]  w_j_next;
  logic [7:0]  w_addr;
  logic [7:0]  w_data;
  logic        w_wren;
  logic [7:0]  w_q;
  logic        w_unused_key;

  assign w_rst_n      = KEY[3];
  assign w_unused_key = ^KEY[2:0];
  assign w_key        = {14'b0, SW};
  // r_kidx tracks i mod 3, so no divider is needed for the key byte.
  assign w_kbyte      = key_byte(w_key, r_kidx);
  assign w_j_next     = r_j + w_q + w_kbyte;

  s_mem s (
    .clk     (CLOCK_50),
    .address (w_addr),
    .data    (w_data),
    .wren    (w_wren),
    .q       (w_q)
  );

  // RAM address/data/write-enable per state; writes are suppressed while reset is held.
  always_comb begin
    w_addr = 8'd0;
    w_data = 8'd0;
    w_wren = 1'b0;
    case (r_state)
      INIT: begin
        w_addr = r_i;
        w_data = r_i;
        w_wren = 1'b1;
      end
      RD_I, WAIT_I: w_addr = r_i;
      CALC_J:       w_addr = w_j_next;
      WAIT_J:       w_addr = r_j;
      WR_I: begin
        w_addr = r_i;
        w_data = w_q;
        w_wren = 1'b1;
      end
      WR_J: begin
        w_addr = r_j;
        w_data = r_si;
        w_wren = 1'b1;
      end
      default: ;
    endcase
    if (!w_rst_n) w_wren = 1'b0;
  end

  // Sequencer and KSA datapath registers, synchronous active-low reset.
  always_ff @(posedge CLOCK_50) begin
    if (!w_rst_n) begin
      r_state <= INIT;
      r_i     <= 8'd0;
      r_j     <= 8'd0;
      r_si    <= 8'd0;
      r_kidx  <= 2'd0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        INIT: begin
          r_i <= r_i + 8'd1;
          if (r_i == 8'hFF) begin
            r_state <= RD_I;
            r_j     <= 8'd0;
            r_kidx  <= 2'd0;
          end
        end
        RD_I:   r_state <= WAIT_I;
        WAIT_I: r_state <= CALC_J;
        CALC_J: begin
          r_si    <= w_q;
          r_j     <= w_j_next;
          r_state <= WAIT_J;
        end
        WAIT_J: r_state <= WR_I;
        WR_I:   r_state <= WR_J;
        WR_J: begin
          if (r_i == 8'hFF) begin
            r_state <= DONE;
            r_done  <= 1'b1;
          end else begin
            r_i     <= r_i + 8'd1;
            r_kidx  <= (r_kidx == 2'd2) ? 2'd0 : r_kidx + 2'd1;
            r_state <= RD_I;
          end
        end
        default: r_state <= DONE;
      endcase
    end
  end

  assign LEDR = {9'b0, r_done};
  assign HEX0 = 7'h7F;
  assign HEX1 = 7'h7F;
  assign HEX2 = 7'h7F;
  assign HEX3 = 7'h7F;
  assign HEX4 = 7'h7F;
  assign HEX5 = 7'h7F;

endmodule

// File: tb/tb_rc4_init_ksa.sv
// Self-checking bench for rc4_init_ksa against a software ARC4 KSA model.
`timescale 1ns/1ps
module tb_rc4_init_ksa;

  logic       CLOCK_50 = 1'b0;
  logic [3:0] KEY = 4'b0111;
  logic [9:0] SW = 10'd0;
  logic [9:0] LEDR;
  logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;

  int n_chk = 0;
  int n_fail = 0;
  int bad_out = 0;
  logic [7:0] m_s [256];

  rc4_init_ksa dut (
    .CLOCK_50 (CLOCK_50),
    .KEY      (KEY),
    .SW       (SW),
    .LEDR     (LEDR),
    .HEX0     (HEX0),
    .HEX1     (HEX1),
    .HEX2     (HEX2),
    .HEX3     (HEX3),
    .HEX4     (HEX4),
    .HEX5     (HEX5)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  // Blank displays and unused LEDs must hold at all times.
  always @(negedge CLOCK_50) begin
    if (HEX0 !== 7'h7F || HEX1 !== 7'h7F || HEX2 !== 7'h7F || HEX3 !== 7'h7F ||
        HEX4 !== 7'h7F || HEX5 !== 7'h7F || LEDR[9:1] !== 9'd0)
      bad_out++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference ARC4 KSA, truncated after 'iters' iterations (0 = identity fill only).
  task automatic model_run(input logic [23:0] key, input int iters);
    int j;
    int kb;
    logic [7:0] t;
    j = 0;
    for (int k = 0; k < 256; k++) m_s[k] = k[7:0];
    for (int i = 0; i < iters; i++) begin
      kb = (key >> (8 * (2 - (i % 3)))) & 255;
      j = (j + m_s[i] + kb) % 256;
      t = m_s[i];
      m_s[i] = m_s[j];
      m_s[j] = t;
    end
  endtask

  task automatic compare_ram(input string tag);
    int diffs;
    diffs = 0;
    for (int k = 0; k < 256; k++)
      if (dut.s.r_mem[k] !== m_s[k]) diffs++;
    chk(tag, diffs, 0);
  endtask

  task automatic start_run(input logic [9:0] key);
    KEY = 4'b0111;
    SW  = key;
    repeat (2) @(negedge CLOCK_50);
    chk("reset_done_low", {31'd0, LEDR[0]}, 0);
    KEY = 4'b1111;
  endtask

  task automatic init_phase(input logic [9:0] key);
    int seen;
    seen = 0;
    repeat (256) begin
      @(negedge CLOCK_50);
      if (LEDR[0] !== 1'b0) seen++;
    end
    chk("init_done_low", seen, 0);
    model_run({14'd0, key}, 0);
    compare_ram("init_identity");
  endtask

  task automatic finish_run(input logic [9:0] key, input int cyc0, input string tag);
    int cyc;
    int cnt;
    bit seen [256];
    cyc = cyc0;
    while (LEDR[0] !== 1'b1 && cyc < 2000) begin
      @(negedge CLOCK_50);
      cyc++;
    end
    chk({tag, "_done_latency"}, (cyc >= 1792 && cyc <= 1800) ? 1 : cyc, 1);
    model_run({14'd0, key}, 256);
    compare_ram({tag, "_final"});
    cnt = 0;
    for (int k = 0; k < 256; k++) seen[k] = 1'b0;
    for (int k = 0; k < 256; k++) begin
      if (!seen[dut.s.r_mem[k]]) cnt++;
      seen[dut.s.r_mem[k]] = 1'b1;
    end
    chk({tag, "_permutation"}, cnt, 256);
    SW = 10'(~key);
    repeat (20) @(negedge CLOCK_50);
    chk({tag, "_done_hold"}, {31'd0, LEDR[0]}, 1);
    compare_ram({tag, "_ram_hold"});
    SW = key;
  endtask

  initial begin
    logic [9:0] rk;

    // Run with a random key first so the next run starts from non-identity contents.
    rk = 10'($urandom_range(0, 1023));
    start_run(rk);
    init_phase(rk);
    finish_run(rk, 256, "rand_pre");

    // Reference key with a per-iteration trace of the first three KSA steps.
    start_run(10'b1100111100);
    init_phase(10'b1100111100);
    for (int it = 0; it < 3; it++) begin
      repeat (6) @(negedge CLOCK_50);
      model_run(24'h00033C, it + 1);
      compare_ram($sformatf("ksa_iter%0d", it));
    end
    chk("iter1_s1", {24'd0, dut.s.r_mem[1]}, 32'h04);
    chk("iter1_s4", {24'd0, dut.s.r_mem[4]}, 32'h01);
    chk("iter2_s2", {24'd0, dut.s.r_mem[2]}, 32'h42);
    chk("iter2_s42", {24'd0, dut.s.r_mem[8'h42]}, 32'h02);
    finish_run(10'b1100111100, 256 + 18, "key33c");

    // Reset in the middle of KSA must restart cleanly.
    start_run(10'b1100111100);
    init_phase(10'b1100111100);
    repeat (600) @(negedge CLOCK_50);
    KEY = 4'b0111;
    repeat (2) @(negedge CLOCK_50);
    chk("abort_done_low", {31'd0, LEDR[0]}, 0);
    KEY = 4'b1111;
    init_phase(10'b1100111100);
    finish_run(10'b1100111100, 256, "abort");

    // All-zero key.
    start_run(10'd0);
    init_phase(10'd0);
    finish_run(10'd0, 256, "key0");

    // A few random keys.
    for (int r = 0; r < 3; r++) begin
      rk = 10'($urandom_range(0, 1023));
      start_run(rk);
      init_phase(rk);
      finish_run(rk, 256, $sformatf("rand%0d", r));
    end

    chk("outputs_constant", bad_out, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
